alu_exec_stage: RTL

//  Execute stage directly downstream of the register-read stage: consumes the 16-bit A/B operand

---
 rtl/alu_exec_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: B shifter, operand selects, ALU with multi-cycle shift-add MUL
module alu_exec_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       aluop,
    input  logic [1:0]       shift,
    input  logic             asel,
    input  logic             bsel,
    input  logic             loadc,
    input  logic             loads,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] sximm5,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       status
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             loadc_q, loadc_d;
    logic             loads_q, loads_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       status_q, status_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] bsh, ain, bin, alu_res, step_acc;
    logic             alu_v;

    always_comb begin
        case (shift)
            2'b01:   bsh = {B[WIDTH-2:0], 1'b0};
            2'b10:   bsh = {1'b0, B[WIDTH-1:1]};
            2'b11:   bsh = {B[WIDTH-1], B[WIDTH-1:1]};
            default: bsh = B;
        endcase
        ain = asel ? '0 : A;
        bin = bsel ? sximm5 : bsh;

        alu_res = '0;
        alu_v   = 1'b0;
        case (aluop)
            3'b000: begin
                alu_res = ain + bin;
                alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b001: begin
                alu_res = ain - bin;
                alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            3'b010:  alu_res = ain & bin;
            3'b011:  alu_res = ~bin;
            default: alu_res = '0;
        endcase

        // One partial product per clock: multiplicand walks left, multiplier walks right.
        step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        loadc_d  = loadc_q;
        loads_d  = loads_q;
        c_d      = c_q;
        status_d = status_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (aluop == 3'b100) begin
                        state_d  = MUL;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = ain;
                        mplier_d = bin;
                        loadc_d  = loadc;
                        loads_d  = loads;
                    end else begin
                        done_d = 1'b1;
                        // Reserved opcodes complete but leave C and status untouched.
                        if (!aluop[2]) begin
                            if (loadc) c_d = alu_res;
                            if (loads) status_d = {alu_res[WIDTH-1], alu_v, alu_res == '0};
                        end
                    end
                end
            end
            MUL: begin
                acc_d    = step_acc;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    if (loadc_q) c_d = step_acc;
                    if (loads_q) status_d = {step_acc[WIDTH-1], 1'b0, step_acc == '0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            loadc_q  <= 1'b0;
            loads_q  <= 1'b0;
            c_q      <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            loadc_q  <= loadc_d;
            loads_q  <= loads_d;
            c_q      <= c_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign C      = c_q;
    assign status = status_q;

endmodule
